// File: rtl/fade_pkg.sv
// fade_pkg
//   Shared definitions for the LED fade sequencer: the envelope phase
//   encoding used on the phase output, by the sequencer FSM and by the
//   testbench.
//   Optional feature macro: FADE_HOLD_EN (enables the HOLD_HI/HOLD_LO phases).
package fade_pkg;

  // Envelope phases. The HOLD_* encodings only ever appear on the phase
  // output when the design is built with FADE_HOLD_EN defined.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } fade_state_e;

endpackage

// File: rtl/fade_step_timer.sv
// fade_step_timer
//   Step-rate prescaler for the fade sequencer. Counts 0..STEP_CYCLES-1
//   while run is high and pulses tick on the last count, then wraps.
//   When run is low the partial count is kept so a frozen envelope resumes
//   with exactly the remaining time.
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-high reset (count -> 0)
//   run    in   1 = advance the count
//   clear  in   1 = force the count back to 0 (wins over run)
//   tick   out  1 while run is high and the count is at STEP_CYCLES-1
module fade_step_timer #(
  parameter int STEP_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  // One extra bit of width keeps STEP_CYCLES=1 legal (count stays at 0).
  localparam int TW = $clog2(STEP_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(STEP_CYCLES - 1);

  logic [TW-1:0] stepCount_q;
  logic [TW-1:0] stepCount_d;

  assign tick = run && (stepCount_q == LAST);

  // Next count: clear has priority, otherwise advance while running and wrap
  // to zero on the tick cycle.
  always_comb begin
    stepCount_d = stepCount_q;
    if (clear) begin
      stepCount_d = '0;
    end else if (run) begin
      if (stepCount_q == LAST) begin
        stepCount_d = '0;
      end else begin
        stepCount_d = stepCount_q + TW'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stepCount_q <= '0;
    end else begin
      stepCount_q <= stepCount_d;
    end
  end

endmodule

// File: rtl/fade_sequencer.sv
// fade_sequencer
//   Brightness-envelope controller for one LED PWM channel. Sequences the
//   duty value through ramp-up / hold-high / ramp-down / hold-low at a fixed
//   step rate so the LED fades continuously.
//   Build option FADE_HOLD_EN: when defined, HOLD_HI and HOLD_LO phases last
//   HOLD_STEPS steps each; when undefined the ramps turn around directly and
//   HOLD_STEPS is ignored.
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   enable      in   1 = run, 0 = freeze all state, counters and output
//   sync        in   1-clk pulse: restart the envelope from level 0
//   pwm_value   out  registered duty level, 0..PWM_INTERVAL
//   phase       out  current envelope phase (fade_pkg::fade_state_e)
//   cycle_done  out  1-clk pulse at the end of each full envelope
module fade_sequencer
  import fade_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEP_CYCLES  = 12000,
  parameter int STEP_SIZE    = 12,
  parameter int HOLD_STEPS   = 100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          sync,
  output logic [$clog2(PWM_INTERVAL):0] pwm_value,
  output logic [2:0]                    phase,
  output logic                          cycle_done
);

  localparam int LW = $clog2(PWM_INTERVAL) + 1;
  localparam logic [LW-1:0] FULL = LW'(PWM_INTERVAL);
  localparam logic [LW-1:0] STEP = LW'(STEP_SIZE);

  // Parameter sanity checks, evaluated at elaboration.
  if (PWM_INTERVAL < 1) begin : gIntervalCheck
    $fatal(1, "fade_sequencer: PWM_INTERVAL must be >= 1");
  end
  if (STEP_CYCLES < 1) begin : gStepCyclesCheck
    $fatal(1, "fade_sequencer: STEP_CYCLES must be >= 1");
  end
  if (STEP_SIZE < 1 || STEP_SIZE > PWM_INTERVAL) begin : gStepSizeCheck
    $fatal(1, "fade_sequencer: STEP_SIZE must be in 1..PWM_INTERVAL");
  end
  if (HOLD_STEPS < 1) begin : gHoldCheck
    $fatal(1, "fade_sequencer: HOLD_STEPS must be >= 1");
  end

  fade_state_e   state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic          cycleDone_q, cycleDone_d;
  logic          tick;
  logic          timerRun;
  logic          timerClear;
  logic [LW:0]   upSum;

`ifdef FADE_HOLD_EN
  localparam int HW = $clog2(HOLD_STEPS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  logic [HW-1:0] holdCount_q, holdCount_d;
`endif

  // The timer only runs once the envelope has left IDLE, and freezes with
  // enable so a paused fade resumes with exactly the remaining step time.
  assign timerRun = enable && (state_q != IDLE);

  fade_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) uStepTimer (
    .clk  (clk),
    .rst  (rst),
    .run  (timerRun),
    .clear(timerClear),
    .tick (tick)
  );

  // Ramp-up sum is one bit wider than the level so it can never wrap before
  // the saturation compare.
  assign upSum = {1'b0, level_q} + {1'b0, STEP};

  // Envelope FSM next-state and level logic. sync overrides everything,
  // including a coincident tick; with enable low nothing changes except
  // that the cycle_done pulse drops.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    cycleDone_d = 1'b0;
    timerClear  = 1'b0;
`ifdef FADE_HOLD_EN
    holdCount_d = holdCount_q;
`endif
    if (sync) begin
      level_d    = '0;
      timerClear = 1'b1;
      state_d    = enable ? UP : IDLE;
`ifdef FADE_HOLD_EN
      holdCount_d = '0;
`endif
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          state_d    = UP;
          timerClear = 1'b1;
        end
        UP: begin
          if (tick) begin
            if (upSum >= {1'b0, FULL}) begin
              level_d = FULL;
`ifdef FADE_HOLD_EN
              state_d = HOLD_HI;
`else
              state_d = DOWN;
`endif
            end else begin
              level_d = upSum[LW-1:0];
            end
          end
        end
        DOWN: begin
          if (tick) begin
            if (level_q <= STEP) begin
              level_d = '0;
`ifdef FADE_HOLD_EN
              state_d = HOLD_LO;
`else
              state_d     = UP;
              cycleDone_d = 1'b1;
`endif
            end else begin
              level_d = level_q - STEP;
            end
          end
        end
`ifdef FADE_HOLD_EN
        HOLD_HI: begin
          if (tick) begin
            if (holdCount_q == HOLD_LAST) begin
              holdCount_d = '0;
              state_d     = DOWN;
            end else begin
              holdCount_d = holdCount_q + HW'(1);
            end
          end
        end
        HOLD_LO: begin
          if (tick) begin
            if (holdCount_q == HOLD_LAST) begin
              holdCount_d = '0;
              state_d     = UP;
              cycleDone_d = 1'b1;
            end else begin
              holdCount_d = holdCount_q + HW'(1);
            end
          end
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, level and pulse registers; outputs come straight from here so
  // there is no combinational path from inputs to outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      level_q     <= '0;
      cycleDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      cycleDone_q <= cycleDone_d;
    end
  end

`ifdef FADE_HOLD_EN
  // Hold-phase step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdCount_q <= '0;
    end else begin
      holdCount_q <= holdCount_d;
    end
  end
`endif

  assign pwm_value  = level_q;
  assign phase      = state_q;
  assign cycle_done = cycleDone_q;

endmodule

// File: tb/tb_fade_sequencer.sv
// tb_fade_sequencer
//   Directed self-checking bench for fade_sequencer with PWM_INTERVAL=10,
//   STEP_CYCLES=4, STEP_SIZE=3, HOLD_STEPS=2. Follows the FADE_HOLD_EN build
//   option so the same bench covers both envelope shapes.
module tb_fade_sequencer;
  import fade_pkg::*;

`ifdef FADE_HOLD_EN
  localparam int          PERIOD    = 48;
  localparam fade_state_e TOP_PHASE = HOLD_HI;
`else
  localparam int          PERIOD    = 32;
  localparam fade_state_e TOP_PHASE = DOWN;
`endif

  logic       clk;
  logic       rst;
  logic       enable;
  logic       sync;
  logic [4:0] pwm_value;
  logic [2:0] phase;
  logic       cycle_done;

  int checks;
  int errors;
  int n;

  fade_sequencer #(
    .PWM_INTERVAL(10),
    .STEP_CYCLES (4),
    .STEP_SIZE   (3),
    .HOLD_STEPS  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .sync      (sync),
    .pwm_value (pwm_value),
    .phase     (phase),
    .cycle_done(cycle_done)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the control inputs.
  task automatic applyStimulus(input logic en, input logic sy);
    enable = en;
    sync   = sy;
  endtask

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic stepClocks(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #2;
    checkOutput("reset pwm", int'(pwm_value), 0);
    checkOutput("reset phase", int'(phase), int'(IDLE));
    checkOutput("reset done", int'(cycle_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    stepClocks(2);
    checkOutput("idle while disabled", int'(phase), int'(IDLE));

    // Ramp up.
    applyStimulus(1'b1, 1'b0);
    stepClocks(1);
    checkOutput("enter up phase", int'(phase), int'(UP));
    checkOutput("enter up pwm", int'(pwm_value), 0);
    stepClocks(3);
    checkOutput("up before first tick", int'(pwm_value), 0);
    stepClocks(1);
    checkOutput("up step 3", int'(pwm_value), 3);
    stepClocks(4);
    checkOutput("up step 6", int'(pwm_value), 6);
    stepClocks(4);
    checkOutput("up step 9", int'(pwm_value), 9);
    stepClocks(4);
    checkOutput("up saturate 10", int'(pwm_value), 10);
    checkOutput("top phase", int'(phase), int'(TOP_PHASE));

`ifdef FADE_HOLD_EN
    stepClocks(4);
    checkOutput("hold hi mid phase", int'(phase), int'(HOLD_HI));
    checkOutput("hold hi mid pwm", int'(pwm_value), 10);
    stepClocks(4);
    checkOutput("hold hi exit phase", int'(phase), int'(DOWN));
    checkOutput("hold hi exit pwm", int'(pwm_value), 10);
`endif

    stepClocks(4);
    checkOutput("down step 7", int'(pwm_value), 7);
    checkOutput("down phase", int'(phase), int'(DOWN));

    // Freeze with two timer counts already consumed.
    stepClocks(2);
    applyStimulus(1'b0, 1'b0);
    stepClocks(20);
    checkOutput("frozen pwm", int'(pwm_value), 7);
    checkOutput("frozen phase", int'(phase), int'(DOWN));
    applyStimulus(1'b1, 1'b0);
    stepClocks(1);
    checkOutput("resume before tick", int'(pwm_value), 7);
    stepClocks(1);
    checkOutput("resume step 4", int'(pwm_value), 4);

    stepClocks(4);
    checkOutput("down step 1", int'(pwm_value), 1);
    stepClocks(4);
    checkOutput("down floor 0", int'(pwm_value), 0);

`ifdef FADE_HOLD_EN
    checkOutput("hold lo phase", int'(phase), int'(HOLD_LO));
    checkOutput("hold lo no done", int'(cycle_done), 0);
    stepClocks(8);
`endif

    checkOutput("wrap phase up", int'(phase), int'(UP));
    checkOutput("wrap done pulse", int'(cycle_done), 1);
    checkOutput("wrap pwm", int'(pwm_value), 0);

    // Envelope period between consecutive cycle_done pulses.
    stepClocks(1);
    checkOutput("done single clk", int'(cycle_done), 0);
    stepClocks(3);
    checkOutput("restart step 3", int'(pwm_value), 3);
    n = 4;
    while (cycle_done !== 1'b1 && n < 200) begin
      stepClocks(1);
      n++;
    end
    checkOutput("envelope period", n, PERIOD);

    // sync on the same edge as a tick while in UP at 6.
    stepClocks(8);
    checkOutput("pre-sync pwm 6", int'(pwm_value), 6);
    stepClocks(3);
    applyStimulus(1'b1, 1'b1);
    stepClocks(1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sync pwm", int'(pwm_value), 0);
    checkOutput("sync phase", int'(phase), int'(UP));
    stepClocks(3);
    checkOutput("sync timer restarted", int'(pwm_value), 0);
    stepClocks(1);
    checkOutput("post-sync step 3", int'(pwm_value), 3);

    // sync while disabled parks the envelope in IDLE.
    applyStimulus(1'b0, 1'b1);
    stepClocks(1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("sync disabled phase", int'(phase), int'(IDLE));
    checkOutput("sync disabled pwm", int'(pwm_value), 0);

    // Climb to the top and reset asynchronously mid-phase.
    applyStimulus(1'b1, 1'b0);
    stepClocks(1);
    checkOutput("re-enable phase", int'(phase), int'(UP));
    stepClocks(16);
    checkOutput("second top pwm", int'(pwm_value), 10);
    stepClocks(2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst pwm", int'(pwm_value), 0);
    checkOutput("async rst phase", int'(phase), int'(IDLE));
    checkOutput("async rst done", int'(cycle_done), 0);
    #5;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
